// File: rtl/pixel_mac_neuron.sv
// pixel_mac_neuron: one neuron of the first MNIST layer.
// Streams NUM_INPUTS Q16.16 pixels and multiplies each by a weight fetched from
// a 1-cycle-latency BRAM. The products are summed in a wrapping 48-bit accumulator.
// The bias word stored after the last weight is then added, an optional ReLU is
// applied, and one saturated 32-bit activation is emitted on a stream master.

module pixel_mac_neuron #(
    parameter int NUM_INPUTS = 784,
    parameter int DATA_W     = 32,
    parameter int FRAC_W     = 16,
    parameter int ACC_W      = 48,
    parameter int USE_RELU   = 1
) (
    input  logic              s_axi_aclk,
    input  logic              s_axi_areset,
    input  logic              start,
    input  logic [31:0]       base_addr,
    output logic [31:0]       w_addr,
    input  logic [DATA_W-1:0] w_rdata,
    input  logic [DATA_W-1:0] x_tdata,
    input  logic              x_tvalid,
    output logic              x_tready,
    output logic [DATA_W-1:0] y_tdata,
    output logic              y_tvalid,
    input  logic              y_tready,
    output logic              busy
);

    localparam int IDX_W   = $clog2(NUM_INPUTS + 1);
    localparam bit RELU_EN = (USE_RELU != 0);

    typedef enum logic [2:0] {IDLE, PRIME, ACCUM, DRAIN, BIAS, OUT} state_t;

    state_t                     state_q;
    logic [IDX_W-1:0]           idx_q;
    logic [ACC_W-1:0]           acc_q;
    logic [ACC_W-1:0]           prod_q;
    logic [ACC_W-1:0]           prod_d;
    logic [ACC_W-1:0]           biasExt;
    logic [ACC_W-1:0]           accAct;
    logic                       prodValid_q;
    logic                       startPrev_q;
    logic                       xReady_q;
    logic                       yValid_q;
    logic                       busy_q;
    logic [31:0]                base_q;
    logic [DATA_W-1:0]          yData_q;
    logic [DATA_W-1:0]          sat_d;
    logic                       startEdge;
    logic                       handshake;
    logic                       lastPixel;
    logic                       fitsOut;
    logic [31:0]                addrIdx;
    logic signed [2*DATA_W-1:0] prodFull;

    assign startEdge = start & ~startPrev_q;
    assign handshake = x_tvalid & xReady_q;
    assign lastPixel = handshake && (idx_q == IDX_W'(NUM_INPUTS - 1));

    // Full-precision signed product, rescaled back to Q16.16 before accumulation
    assign prodFull = $signed(x_tdata) * $signed(w_rdata);
    assign prod_d   = ACC_W'(prodFull >>> FRAC_W);
    assign biasExt  = {{(ACC_W-DATA_W){w_rdata[DATA_W-1]}}, w_rdata};

    // Output stage: optional ReLU, then clamp the wide sum into the 32-bit range
    assign accAct  = (RELU_EN && acc_q[ACC_W-1]) ? '0 : acc_q;
    assign fitsOut = (&accAct[ACC_W-1:DATA_W-1]) | ~(|accAct[ACC_W-1:DATA_W-1]);
    assign sat_d   = fitsOut ? accAct[DATA_W-1:0]
                   : (accAct[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                      : {1'b0, {(DATA_W-1){1'b1}}});

    assign x_tready = xReady_q;
    assign y_tdata  = yData_q;
    assign y_tvalid = yValid_q;
    assign busy     = busy_q;

    // Weight address looks one pixel ahead on a handshake so w_rdata always matches idx
    always_comb begin
        addrIdx = 32'(idx_q) + (handshake ? 32'd1 : 32'd0);
        w_addr  = '0;
        case (state_q)
            PRIME, ACCUM: w_addr = base_q + (addrIdx << 2);
            DRAIN, BIAS:  w_addr = base_q + (32'(NUM_INPUTS) << 2);
            default:      w_addr = '0;
        endcase
    end

    // Frame sequencing, one-stage multiply pipe and registered stream outputs
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            acc_q       <= '0;
            prod_q      <= '0;
            prodValid_q <= 1'b0;
            startPrev_q <= 1'b0;
            xReady_q    <= 1'b0;
            yValid_q    <= 1'b0;
            yData_q     <= '0;
            busy_q      <= 1'b0;
            base_q      <= '0;
        end else begin
            startPrev_q <= start;
            prodValid_q <= handshake;
            if (handshake) begin
                prod_q <= prod_d;
            end
            case (state_q)
                IDLE: begin
                    if (startEdge) begin
                        base_q  <= base_addr;
                        idx_q   <= '0;
                        acc_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= PRIME;
                    end
                end
                PRIME: begin
                    xReady_q <= 1'b1;
                    state_q  <= ACCUM;
                end
                ACCUM: begin
                    if (prodValid_q) begin
                        acc_q <= acc_q + prod_q;
                    end
                    if (handshake) begin
                        idx_q <= idx_q + 1'b1;
                    end
                    if (lastPixel) begin
                        xReady_q <= 1'b0;
                        state_q  <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (prodValid_q) begin
                        acc_q <= acc_q + prod_q;
                    end
                    state_q <= BIAS;
                end
                BIAS: begin
                    acc_q   <= acc_q + biasExt;
                    state_q <= OUT;
                end
                OUT: begin
                    if (!yValid_q) begin
                        yData_q  <= sat_d;
                        yValid_q <= 1'b1;
                    end else if (y_tready) begin
                        yValid_q <= 1'b0;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
